// File: rtl/stream_serializer_if.sv
// stream_serializer_if: handshake bundle for the narrowing serializer.
//   push side : io_push_valid/ready, io_push_payload (IN_WIDTH), io_push_count (CW),
//               io_push_last
//   pop side  : io_pop_valid/ready, io_pop_payload (OUT_WIDTH), io_pop_last
//   control   : io_flush (in), io_busy (out)
// modport slave  - the serializer itself
// modport master - its environment (word producer plus the downstream FIFO ready)
interface stream_serializer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic                 io_push_valid;
  logic                 io_push_ready;
  logic [IN_WIDTH-1:0]  io_push_payload;
  logic [CW-1:0]        io_push_count;
  logic                 io_push_last;
  logic                 io_pop_valid;
  logic                 io_pop_ready;
  logic [OUT_WIDTH-1:0] io_pop_payload;
  logic                 io_pop_last;
  logic                 io_flush;
  logic                 io_busy;

  modport slave (
    input  io_push_valid, io_push_payload, io_push_count, io_push_last,
    input  io_pop_ready, io_flush,
    output io_push_ready, io_pop_valid, io_pop_payload, io_pop_last, io_busy
  );

  modport master (
    output io_push_valid, io_push_payload, io_push_count, io_push_last,
    output io_pop_ready, io_flush,
    input  io_push_ready, io_pop_valid, io_pop_payload, io_pop_last, io_busy
  );
endinterface

// File: rtl/stream_serializer.sv
// stream_serializer: narrowing width adapter. Takes IN_WIDTH-bit words with a
// beat count (count+1 beats) and a packet-end flag, emits OUT_WIDTH-bit beats.
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   io    - stream_serializer_if.slave (push stream, pop stream, flush, busy)
// Build option: define STREAM_SERIALIZER_MSB_FIRST_EN to emit beats MSB-first
// (default is LSB-first). Handshake, latency and last behaviour are unchanged.
module stream_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  stream_serializer_if.slave io
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(RATIO - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t               r_state;
  logic [IN_WIDTH-1:0]  r_word;
  logic [CW-1:0]        r_remaining;
  logic                 r_last;

  logic                 w_push_ready;
  logic                 w_push_fire;
  logic                 w_pop_fire;
  logic [CW-1:0]        w_count;
  logic [IN_WIDTH-1:0]  w_word_shifted;

  // Counts above RATIO-1 only exist when RATIO is not a power of two.
  generate
    if ((1 << CW) == RATIO) begin : g_pow2
      assign w_count = io.io_push_count;
    end else begin : g_clamp
      assign w_count = (io.io_push_count > MAX_CNT) ? MAX_CNT : io.io_push_count;
    end
  endgenerate

  // A new word is taken when nothing is held, or as the last beat of the
  // held word leaves, which gives back-to-back words without a bubble.
  // Gated with reset so the push side is closed while reset is asserted.
  assign w_push_ready = reset && !io.io_flush &&
                        ((r_state == IDLE) || ((r_remaining == '0) && io.io_pop_ready));
  assign w_push_fire  = io.io_push_valid && w_push_ready;
  assign w_pop_fire   = (r_state == SHIFT) && io.io_pop_ready;

`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
  assign io.io_pop_payload = r_word[IN_WIDTH-1 -: OUT_WIDTH];
  assign w_word_shifted    = r_word << OUT_WIDTH;
`else
  assign io.io_pop_payload = r_word[OUT_WIDTH-1:0];
  assign w_word_shifted    = r_word >> OUT_WIDTH;
`endif

  assign io.io_push_ready = w_push_ready;
  assign io.io_pop_valid  = (r_state == SHIFT);
  assign io.io_pop_last   = (r_state == SHIFT) && (r_remaining == '0) && r_last;
  assign io.io_busy       = (r_state == SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_remaining <= '0;
      r_last      <= 1'b0;
    end else if (io.io_flush) begin
      // Held word is dropped; a beat popped in this cycle was already legal.
      r_state     <= IDLE;
      r_word      <= '0;
      r_remaining <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push_fire) begin
            r_state     <= SHIFT;
            r_word      <= io.io_push_payload;
            r_remaining <= w_count;
            r_last      <= io.io_push_last;
          end
        end
        SHIFT: begin
          if (w_pop_fire) begin
            if (r_remaining != '0) begin
              r_word      <= w_word_shifted;
              r_remaining <= r_remaining - CW'(1);
            end else if (w_push_fire) begin
              r_word      <= io.io_push_payload;
              r_remaining <= w_count;
              r_last      <= io.io_push_last;
            end else begin
              r_state     <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_serializer.sv
module tb_stream_serializer;
  localparam int IW = 32;
  localparam int OW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_serializer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) io ();
  stream_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic [7:0] d; logic l; logic pr; int cyc; } log_t;

  beat_t q[$];   // model: beats still owed by the words accepted so far
  log_t  lg[$];  // beats actually observed leaving the DUT
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic        p_push = 1'b0, p_pop = 1'b0, p_flush = 1'b0, p_last = 1'b0;
  logic [31:0] p_pay  = '0;
  logic [1:0]  p_cnt  = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Word whose beats leave in the order b0,b1,b2,b3 for the build in use.
  function automatic logic [31:0] mkw(input logic [7:0] b0, b1, b2, b3);
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model update: a word becomes count+1 queued beats; only the final one
  // carries the word's last flag.
  always @(posedge clk or negedge reset) begin
    beat_t b;
    if (!reset) q.delete();
    else begin
      if (p_pop) void'(q.pop_front());
      if (p_flush) q.delete();
      if (p_push) begin
        for (int k = 0; k <= int'(p_cnt); k++) begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
          b.d = 8'(p_pay >> (IW - OW * (k + 1)));
`else
          b.d = 8'(p_pay >> (OW * k));
`endif
          b.l = p_last && (k == int'(p_cnt));
          q.push_back(b);
        end
      end
    end
  end

  // Compare on every falling edge, then latch what fires at the next rise.
  always @(negedge clk) begin
    logic exp_pr;
    exp_pr = reset && !io.io_flush &&
             (q.size() == 0 || (q.size() == 1 && io.io_pop_ready));
    check("pop_valid", io.io_pop_valid, q.size() != 0);
    check("busy", io.io_busy, q.size() != 0);
    check("push_ready", io.io_push_ready, exp_pr);
    if (q.size() != 0) begin
      check("pop_payload", io.io_pop_payload, q[0].d);
      check("pop_last", io.io_pop_last, q[0].l);
    end else begin
      check("pop_last_idle", io.io_pop_last, 1'b0);
      if (!reset) check("payload_in_reset", io.io_pop_payload, 8'h00);
    end
    p_push  = io.io_push_valid && exp_pr;
    p_pop   = reset && (q.size() != 0) && io.io_pop_ready;
    p_flush = reset && io.io_flush;
    p_pay   = io.io_push_payload;
    p_cnt   = io.io_push_count;
    p_last  = io.io_push_last;
    if (io.io_pop_valid && io.io_pop_ready)
      lg.push_back('{d: io.io_pop_payload, l: io.io_pop_last, pr: io.io_push_ready, cyc: cyc});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [1:0] c, input logic l);
    logic ok = 1'b0;
    io.io_push_valid = 1'b1; io.io_push_payload = w;
    io.io_push_count = c;    io.io_push_last    = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io.io_push_ready) begin ok = 1'b1; break; end
    end
    step();
    io.io_push_valid = 1'b0;
    check("push_accept_timeout", ok, 1'b1);
  endtask

  task automatic drain();
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !io.io_pop_valid) begin ok = 1'b1; break; end
    end
    step();
    check("drain_timeout", ok, 1'b1);
  endtask

  // exp holds beat k in bits [8k+7:8k]; t0 < 0 skips the cycle-position check.
  task automatic check_log(input string name, input logic [63:0] exp, input int n,
                           input logic [7:0] lmask, input int t0);
    check({name, "_nbeats"}, lg.size(), n);
    for (int k = 0; k < n && k < lg.size(); k++) begin
      check({name, "_data"}, lg[k].d, 8'(exp >> (8 * k)));
      check({name, "_last"}, lg[k].l, lmask[k]);
      if (t0 >= 0) check({name, "_cycle"}, lg[k].cyc, t0 + k);
    end
  endtask

  initial begin
    int t0;
    logic [3:0] pat;
    io.io_push_valid = 1'b0; io.io_push_payload = '0; io.io_push_count = '0;
    io.io_push_last  = 1'b0; io.io_pop_ready = 1'b1;  io.io_flush = 1'b0;

    // Reset state, with push_valid high to show ready is held low.
    #1 reset = 1'b0;
    io.io_push_valid = 1'b1;
    #2;
    check("rst_pop_valid", io.io_pop_valid, 1'b0);
    check("rst_busy", io.io_busy, 1'b0);
    check("rst_payload", io.io_pop_payload, 8'h00);
    check("rst_last", io.io_pop_last, 1'b0);
    check("rst_push_ready", io.io_push_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    io.io_push_valid = 1'b0;
    step();

    // Single full word.
    lg.delete();
    push_word(mkw(8'hD4, 8'hC3, 8'hB2, 8'hA1), 2'd3, 1'b1);
    t0 = cyc;
    drain();
    check_log("full", 64'hA1B2C3D4, 4, 8'b1000, t0);
    if (lg.size() == 4) begin
      check("full_ready_beat0", lg[0].pr, 1'b0);
      check("full_ready_beat3", lg[3].pr, 1'b1);
    end

    // Back-to-back words, push_valid held across the handover.
    lg.delete();
    push_word(mkw(8'h01, 8'h02, 8'h03, 8'h04), 2'd3, 1'b0);
    t0 = cyc;
    push_word(mkw(8'h05, 8'h06, 8'h07, 8'h08), 2'd3, 1'b1);
    drain();
    check_log("b2b", 64'h0807060504030201, 8, 8'h80, t0);
    if (lg.size() == 8) check("b2b_accept_on_04", lg[3].pr, 1'b1);

    // Partial word.
    lg.delete();
    push_word(mkw(8'hEF, 8'hBE, 8'h00, 8'h00), 2'd1, 1'b1);
    t0 = cyc;
    drain();
    check_log("part", 64'hBEEF, 2, 8'b10, t0);
    check("part_idle", io.io_busy, 1'b0);

    // Backpressure with pop_ready pattern 1,0,0,1.
    lg.delete();
    io.io_pop_ready = 1'b0;
    push_word(mkw(8'h21, 8'h43, 8'h65, 8'h87), 2'd3, 1'b0);
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      io.io_pop_ready = pat[3 - (i % 4)];
      step();
    end
    io.io_pop_ready = 1'b1;
    drain();
    check_log("bp", 64'h87654321, 4, 8'b0000, -1);
    if (lg.size() == 4) begin
      check("bp_ready_beat2", lg[2].pr, 1'b0);
      check("bp_ready_beat3", lg[3].pr, 1'b1);
    end

    // Flush in the cycle beat 1 leaves; a push offered then must wait.
    lg.delete();
    push_word(mkw(8'h44, 8'h33, 8'h22, 8'h11), 2'd3, 1'b1);
    step();
    io.io_flush = 1'b1;
    io.io_push_valid = 1'b1; io.io_push_payload = mkw(8'h55, 8'h00, 8'h00, 8'h00);
    io.io_push_count = 2'd0; io.io_push_last = 1'b1;
    step();
    io.io_flush = 1'b0;
    check("flush_pop_valid", io.io_pop_valid, 1'b0);
    check("flush_busy", io.io_busy, 1'b0);
    push_word(mkw(8'h55, 8'h00, 8'h00, 8'h00), 2'd0, 1'b1);
    drain();
    check_log("flush", 64'h553344, 3, 8'b100, -1);

    // Asynchronous reset mid-word, between clock edges.
    lg.delete();
    push_word(mkw(8'h0D, 8'hF0, 8'hFE, 8'hCA), 2'd3, 1'b1);
    @(posedge clk); #4;
    reset = 1'b0;
    #1;
    check("arst_pop_valid", io.io_pop_valid, 1'b0);
    check("arst_busy", io.io_busy, 1'b0);
    step();
    reset = 1'b1;
    repeat (3) step();
    check("arst_stays_idle", io.io_pop_valid, 1'b0);
    check_log("arst", 64'h0D, 1, 8'b0, -1);

    // Recovery after reset.
    lg.delete();
    push_word(mkw(8'h77, 8'h00, 8'h00, 8'h00), 2'd0, 1'b1);
    t0 = cyc;
    drain();
    check_log("recover", 64'h77, 1, 8'b1, t0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
